// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two 2-deep writeback FIFOs (A = ALU, B = load)
// drained round-robin into one registered write port, with scoreboard-style busy lookups.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              pending
);

  // Handshake: a transfer happens on a rising edge where x_valid && x_ready;
  // the requester holds x_rd/x_data stable while x_valid && !x_ready.
  // Index 0 is requester A, index 1 is requester B.
  logic              in_valid [2];
  logic [ADDR_W-1:0] in_rd    [2];
  logic [DATA_W-1:0] in_data  [2];

  logic [ADDR_W-1:0] rd_q   [2][2];
  logic [DATA_W-1:0] data_q [2][2];
  logic [1:0]        cnt    [2];
  logic              wp     [2];
  logic              rp     [2];
  logic              prio_b;

  logic              room     [2];
  logic              push     [2];
  logic              nonempty [2];
  logic              grant    [2];

  assign in_valid[0] = a_valid;
  assign in_valid[1] = b_valid;
  assign in_rd[0]    = a_rd;
  assign in_rd[1]    = b_rd;
  assign in_data[0]  = a_data;
  assign in_data[1]  = b_data;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      room[r]     = (cnt[r] != 2'd2);
      nonempty[r] = (cnt[r] != 2'd0);
      // rd==0 writes are consumed by the handshake but never stored
      push[r]     = in_valid[r] && room[r] && (in_rd[r] != '0) && !reset;
    end
    grant[0] = nonempty[0] && (!nonempty[1] || !prio_b);
    grant[1] = nonempty[1] && !grant[0];
  end

  // Ready only looks at the registered count, so a same-cycle pop never raises it.
  assign a_ready = room[0] || reset;
  assign b_ready = room[1] || reset;

  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        rd_q[r][wp[r]]   <= in_rd[r];
        data_q[r][wp[r]] <= in_data[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        cnt[r] <= 2'd0;
        wp[r]  <= 1'b0;
        rp[r]  <= 1'b0;
      end
      prio_b    <= 1'b0;
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r])  wp[r] <= ~wp[r];
        if (grant[r]) rp[r] <= ~rp[r];
        cnt[r] <= cnt[r] + {1'b0, push[r]} - {1'b0, grant[r]};
      end
      if (grant[0]) begin
        RegWrite  <= 1'b1;
        RD        <= rd_q[0][rp[0]];
        WriteData <= data_q[0][rp[0]];
        prio_b    <= 1'b1;
      end else if (grant[1]) begin
        RegWrite  <= 1'b1;
        RD        <= rd_q[1][rp[1]];
        WriteData <= data_q[1][rp[1]];
        prio_b    <= 1'b0;
      end else begin
        RegWrite  <= 1'b0;
      end
    end
  end

  // An entry is live when the FIFO is full, or it is the head of a 1-entry FIFO.
  always_comb begin
    logic hit1;
    logic hit2;
    logic live;
    hit1 = RegWrite && (RD == rs1);
    hit2 = RegWrite && (RD == rs2);
    live = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int e = 0; e < 2; e++) begin
        live = (cnt[r] == 2'd2) || ((cnt[r] == 2'd1) && (rp[r] == 1'(e)));
        if (live && (rd_q[r][e] == rs1)) hit1 = 1'b1;
        if (live && (rd_q[r][e] == rs2)) hit2 = 1'b1;
      end
    end
    rs1_busy = hit1 && (rs1 != '0) && !reset;
    rs2_busy = hit2 && (rs2 != '0) && !reset;
    pending  = (nonempty[0] || nonempty[1] || RegWrite) && !reset;
  end

endmodule
